det5_matrix_loader: RTL and testbench
=====================================

// Module: det5_matrix_loader
// PURPOSE
//   Upstream front end of the 5x5 determinant core. Accepts the 25 signed 8-bit
//   matrix elements one per cycle over a valid/ready stream, in row-major order.
//   Holds them as a flat matrix bus and issues start to the core. Captures the
//   core's 16-bit result and presents it on a valid/ready output, with a
//   watchdog error flag.
// PARAMETERS
//   N            5     matrix order (fixed at 5; the flat bus is N*N*DATA_W bits)
//   DATA_W       8     element width, two's complement
//   RES_W        16    determinant result width, two's complement
//   TIMEOUT_CYC  1024  max cycles in WAIT before declaring an error (>=2)
// PORTS
//   clk        in   1             rising-edge clock
//   rst        in   1             asynchronous, active-high reset
//   in_valid   in   1             element available
//   in_data    in   DATA_W        element value
//   in_ready   out  1             element accepted when in_valid & in_ready
//   mat_flat   out  N*N*DATA_W    element k=row*N+col at [DATA_W*k +: DATA_W]
//   det_start  out  1             start level to determinant core
//   det_done   in   1             core completion
//   det_result in   RES_W         core result, valid while det_done=1
//   res_valid  out  1             result available
//   res_ready  in   1             consumer accepts when res_valid & res_ready
//   res_data   out  RES_W         determinant (0 on error)
//   res_err    out  1             1 = watchdog expired, res_data invalid
// BEHAVIOUR
//   Reset (async, any state): state=LOAD, idx=0, wdog=0, in_ready=1,
//     det_start=0, res_valid=0, res_data=0, res_err=0, mat_flat=0.
//   FSM states: LOAD, ISSUE, WAIT, OUT. All outputs are registered.
//   LOAD:  in_ready=1. On each accepted beat, mat_flat[idx] is written and idx
//          is incremented. The beat with idx==24 goes to ISSUE; idx is reset to 0.
//          No beat means no change. Gaps in in_valid are allowed.
//   ISSUE: in_ready=0, det_start=1. det_done is ignored in this cycle, because
//          the core may still hold done from a previous run. Next state is
//          WAIT; wdog is cleared.
//   WAIT:  det_start is held at 1, and wdog increments every cycle.
//          - det_done=1: res_data<=det_result, res_err<=0, det_start<=0 (falls
//            in the same edge), next state OUT.
//          - Otherwise, when wdog==TIMEOUT_CYC-1: res_data<=0, res_err<=1,
//            det_start<=0, next state OUT.
//          - If det_done and the timeout coincide, det_done wins.
//   OUT:   res_valid=1, and res_data/res_err are held stable until res_ready=1.
//          On acceptance: res_valid<=0, next state LOAD, in_ready<=1 next cycle.
//          res_ready while res_valid=0 is ignored.
//   mat_flat holds its value from ISSUE through OUT. It is not cleared between
//   matrices; it is only overwritten element by element.
//   in_valid outside LOAD is ignored and no data is consumed.
//   Latency: last element accepted at edge E, det_start=1 after E+1,
//     earliest done sample at E+2, res_valid=1 one cycle after the done sample.
//   The result is passed through unmodified. No saturation or width conversion
//   is performed; RES_W must equal the core result width.
//   Reset mid-operation drops the partial matrix and any pending result.
//   det_start=0 immediately on reset.
// TESTING
//   1. Identity matrix (diagonal 1, else 0), core stub returns 16'sd1 after 20 cycles
//      -> one det_start run, res_data=1, res_err=0, mat_flat[7:0]=1, [15:8]=0.
//   2. Elements k=0..24 fed as value k, with in_valid toggling 1/0 each cycle
//      -> mat_flat[8k+:8]==k; det_start rises exactly once, 1 cycle after the 25th beat.
//   3. Stub holds det_done=1 continuously from the previous run
//      -> the done is ignored in ISSUE, accepted in WAIT, and the result is taken
//      from det_result (0x0123 = 291).
//   4. TIMEOUT_CYC=8, stub never asserts done
//      -> after 8 WAIT cycles: res_valid=1, res_err=1, res_data=0, det_start=0.
//   5. res_ready held 0 for 10 cycles in OUT with in_valid=1
//      -> res_data stable, in_ready=0, nothing consumed. res_ready=1 -> LOAD next cycle.
//   6. rst pulsed after 13 elements, then 25 fresh elements
//      -> outputs reset at once, and the next det_start follows only the 25th new beat.

Source files
------------

// File: rtl/det5_matrix_loader.sv
// Front end of the 5x5 determinant core: gathers 25 streamed elements into a flat matrix bus,
// starts the core, and returns its result (or a watchdog error) over a valid/ready output.
module det5_matrix_loader #(
  parameter int unsigned N           = 5,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RES_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  input  logic [DATA_W-1:0]       in_data_i,
  output logic                    in_ready_o,
  output logic [N*N*DATA_W-1:0]   mat_flat_o,
  output logic                    det_start_o,
  input  logic                    det_done_i,
  input  logic [RES_W-1:0]        det_result_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [RES_W-1:0]        res_data_o,
  output logic                    res_err_o
);

  localparam int unsigned NumEl = N * N;
  localparam int unsigned IdxW  = $clog2(NumEl);
  localparam int unsigned WdW   = $clog2(TIMEOUT_CYC);
  localparam int unsigned MatW  = NumEl * DATA_W;

  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumEl - 1);
  localparam logic [WdW-1:0]  WdogLast = WdW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] StLoad  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StOut   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WdW-1:0]   wdog_q, wdog_d;
  logic             in_ready_q, in_ready_d;
  logic             det_start_q, det_start_d;
  logic             res_valid_q, res_valid_d;
  logic [RES_W-1:0] res_data_q, res_data_d;
  logic             res_err_q, res_err_d;
  logic [MatW-1:0]  mat_q, mat_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wdog_d      = wdog_q;
    in_ready_d  = in_ready_q;
    det_start_d = det_start_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    mat_d       = mat_q;

    case (state_q)
      StLoad: begin
        if (in_valid_i && in_ready_q) begin
          mat_d[idx_q*DATA_W +: DATA_W] = in_data_i;
          if (idx_q == IdxLast) begin
            idx_d      = '0;
            in_ready_d = 1'b0;
            state_d    = StIssue;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      // det_done is deliberately not looked at here: the core may still hold it from last run.
      StIssue: begin
        det_start_d = 1'b1;
        wdog_d      = '0;
        state_d     = StWait;
      end
      StWait: begin
        wdog_d = wdog_q + 1'b1;
        if (det_done_i) begin
          res_data_d  = det_result_i;
          res_err_d   = 1'b0;
          det_start_d = 1'b0;
          res_valid_d = 1'b1;
          state_d     = StOut;
        end else if (wdog_q == WdogLast) begin
          res_data_d  = '0;
          res_err_d   = 1'b1;
          det_start_d = 1'b0;
          res_valid_d = 1'b1;
          state_d     = StOut;
        end
      end
      StOut: begin
        if (res_valid_q && res_ready_i) begin
          res_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StLoad;
      idx_q       <= '0;
      wdog_q      <= '0;
      in_ready_q  <= 1'b1;
      det_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      mat_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wdog_q      <= wdog_d;
      in_ready_q  <= in_ready_d;
      det_start_q <= det_start_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      mat_q       <= mat_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign mat_flat_o  = mat_q;
  assign det_start_o = det_start_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_err_o   = res_err_q;

endmodule

// File: tb/tb_det5_matrix_loader.sv
// Bench for det5_matrix_loader: a long-timeout instance driven by a core stub and a
// short-timeout instance whose core never finishes, checked against a matrix/result model.
module tb_det5_matrix_loader;

  typedef struct {
    int          sel;       // 0: stub-driven instance, 1: timeout-8 instance
    int          pattern;   // 0 identity, 1 ramp k, 2 random
    int          gap;       // 0 none, 1 toggle, 2 random
    int          lat;
    logic        hold;
    logic [15:0] val;
    int          rr;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, res_ready, sel;
  logic [7:0]  in_data;
  logic        det_done;
  logic [15:0] det_result;

  logic         iv1, iv2, rr1, rr2;
  logic         ir1, ir2, ds1, ds2, rv1, rv2, re1, re2;
  logic [199:0] mat1, mat2;
  logic [15:0]  rd1, rd2;
  logic         ir, ds, rv, re;
  logic [199:0] mat;
  logic [15:0]  rd;

  assign iv1 = in_valid & ~sel;
  assign iv2 = in_valid & sel;
  assign rr1 = res_ready & ~sel;
  assign rr2 = res_ready & sel;
  assign ir  = sel ? ir2 : ir1;
  assign ds  = sel ? ds2 : ds1;
  assign rv  = sel ? rv2 : rv1;
  assign re  = sel ? re2 : re1;
  assign rd  = sel ? rd2 : rd1;
  assign mat = sel ? mat2 : mat1;

  det5_matrix_loader #(.TIMEOUT_CYC(1024)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv1), .in_data_i(in_data), .in_ready_o(ir1),
    .mat_flat_o(mat1), .det_start_o(ds1), .det_done_i(det_done), .det_result_i(det_result),
    .res_valid_o(rv1), .res_ready_i(rr1), .res_data_o(rd1), .res_err_o(re1)
  );

  det5_matrix_loader #(.TIMEOUT_CYC(8)) u_dut_to (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv2), .in_data_i(in_data), .in_ready_o(ir2),
    .mat_flat_o(mat2), .det_start_o(ds2), .det_done_i(1'b0), .det_result_i(16'h5A5A),
    .res_valid_o(rv2), .res_ready_i(rr2), .res_data_o(rd2), .res_err_o(re2)
  );

  // Core stub: raises done stub_lat WAIT cycles after start, or holds done forever.
  int          stub_lat  = 1;
  int          stub_cnt  = 0;
  logic        stub_hold = 1'b0;
  logic [15:0] stub_val  = 16'h0000;

  initial begin
    det_done   = 1'b0;
    det_result = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (stub_hold) begin
        det_done   = 1'b1;
        det_result = stub_val;
      end else if (ds1) begin
        stub_cnt++;
        if (stub_cnt >= stub_lat) begin
          det_done   = 1'b1;
          det_result = stub_val;
        end
      end else begin
        stub_cnt   = 0;
        det_done   = 1'b0;
        det_result = 16'hDEAD;
      end
    end
  end

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] mdl [2][25];
  logic [7:0] cur [25];

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [199:0] pack(input int s);
    logic [199:0] p;
    for (int k = 0; k < 25; k++) p[8*k +: 8] = mdl[s][k];
    return p;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 25; k++) mdl[s][k] = 8'h00;
  endtask

  task automatic feed(input int gap, output int beats, output logic bad);
    int   cyc;
    logic von;
    beats = 0;
    cyc   = 0;
    bad   = 1'b0;
    while (beats < 25 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (ds !== 1'b0 || ir !== 1'b1) bad = 1'b1;
      von      = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
      in_valid = von;
      in_data  = von ? cur[beats] : 8'($urandom);
      if (von) begin
        mdl[sel][beats] = cur[beats];
        beats++;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   beats, n;
    logic bad;
    sel       = 1'(v.sel);
    stub_lat  = v.lat;
    stub_hold = v.hold;
    stub_val  = v.val;
    for (int k = 0; k < 25; k++)
      cur[k] = (v.pattern == 0) ? ((k % 6 == 0) ? 8'd1 : 8'd0) :
               (v.pattern == 1) ? 8'(k) : 8'($urandom);
    feed(v.gap, beats, bad);
    chk("load_beats", 200'(beats), 200'd25);
    chk("load_ready_no_start", {199'd0, bad}, 200'd0);
    // ISSUE: stray input must be ignored from here on
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    chk("issue_in_ready", {199'd0, ir}, 200'd0);
    chk("issue_start_low", {199'd0, ds}, 200'd0);
    @(negedge clk);
    chk("wait_start_high", {199'd0, ds}, 200'd1);
    n   = 0;
    bad = 1'b0;
    while (rv !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
      in_data = 8'($urandom);
      if (rv !== 1'b1 && ds !== 1'b1) bad = 1'b1;
    end
    chk("wait_start_held", {199'd0, bad}, 200'd0);
    chk("wait_cycles", 200'(n), 200'(v.exp_lat));
    chk("res_data", 200'(rd), 200'(v.exp_data));
    chk("res_err", {199'd0, re}, {199'd0, v.exp_err});
    chk("start_fall", {199'd0, ds}, 200'd0);
    chk("mat_flat", mat, pack(v.sel));
    bad = 1'b0;
    repeat (v.rr) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 8'($urandom);
      res_ready = 1'b0;
      if (rd !== v.exp_data || re !== v.exp_err || rv !== 1'b1 || ir !== 1'b0 ||
          mat !== pack(v.sel)) bad = 1'b1;
    end
    chk("out_hold", {199'd0, bad}, 200'd0);
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    in_valid  = 1'b0;
    chk("accept_valid", {199'd0, rv}, 200'd0);
    chk("accept_ready", {199'd0, ir}, 200'd1);
    chk("accept_mat", mat, pack(v.sel));
  endtask

  vec_t tbl [6];

  initial begin
    int   beats;
    logic bad;
    vec_t rv_vec;

    tbl[0] = '{0, 0, 0, 20, 1'b0, 16'h0001, 0, 16'h0001, 1'b0, 20};
    tbl[1] = '{0, 1, 1, 5, 1'b0, 16'hBEEF, 1, 16'hBEEF, 1'b0, 5};
    tbl[2] = '{0, 2, 0, 50, 1'b1, 16'h0123, 0, 16'h0123, 1'b0, 1};
    tbl[3] = '{0, 2, 0, 3, 1'b0, 16'h8000, 10, 16'h8000, 1'b0, 3};
    tbl[4] = '{1, 1, 0, 0, 1'b0, 16'h0000, 2, 16'h0000, 1'b1, 8};
    tbl[5] = '{0, 2, 2, 1, 1'b0, 16'hFFFF, 2, 16'hFFFF, 1'b0, 1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    res_ready = 1'b0;
    sel       = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_in_ready", {199'd0, ir}, 200'd1);
      chk("rst_start", {199'd0, ds}, 200'd0);
      chk("rst_res_valid", {199'd0, rv}, 200'd0);
      chk("rst_res_data", 200'(rd), 200'd0);
      chk("rst_res_err", {199'd0, re}, 200'd0);
      chk("rst_mat", mat, 200'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Reset after 13 elements: partial matrix dropped, count restarts
    sel = 1'b0;
    for (int k = 0; k < 25; k++) cur[k] = 8'(100 + k);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = cur[k];
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    clear_model();
    #1;
    chk("midload_rst_mat", mat, 200'd0);
    chk("midload_rst_ready", {199'd0, ir}, 200'd1);
    @(negedge clk);
    rst = 1'b0;
    run_vec('{0, 1, 0, 4, 1'b0, 16'h1234, 0, 16'h1234, 1'b0, 4});

    // Reset while waiting on the core: start must drop at once
    stub_lat = 1000;
    for (int k = 0; k < 25; k++) cur[k] = 8'($urandom);
    feed(0, beats, bad);
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    chk("midwait_start", {199'd0, ds}, 200'd1);
    rst = 1'b1;
    clear_model();
    #1;
    chk("midwait_rst_start", {199'd0, ds}, 200'd0);
    chk("midwait_rst_valid", {199'd0, rv}, 200'd0);
    chk("midwait_rst_ready", {199'd0, ir}, 200'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 20; r++) begin
      rv_vec.sel      = ($urandom_range(0, 3) == 0) ? 1 : 0;
      rv_vec.pattern  = 2;
      rv_vec.gap      = int'($urandom_range(0, 2));
      rv_vec.lat      = int'($urandom_range(1, 12));
      rv_vec.hold     = 1'b0;
      rv_vec.val      = 16'($urandom);
      rv_vec.rr       = int'($urandom_range(0, 4));
      rv_vec.exp_data = (rv_vec.sel == 1) ? 16'h0000 : rv_vec.val;
      rv_vec.exp_err  = (rv_vec.sel == 1);
      rv_vec.exp_lat  = (rv_vec.sel == 1) ? 8 : rv_vec.lat;
      run_vec(rv_vec);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
